trigger_event_logger: RTL and testbench
=======================================

// Module: trigger_event_logger
// PURPOSE
// - Downstream consumer of the TSC trigger output in the AES-T2800 TjIn path.
// - Detects each rising edge of trigger and records the cycle timestamp in a small FIFO.
// - Drives a sticky alarm and a saturating event count so the bench and on-chip debug can observe activation.
// - Passive monitor: never feeds back into the AES datapath.
// PARAMETERS
// - TS_W     16  width of the free-running timestamp counter and of each FIFO entry
// - DEPTH    4   FIFO entries; must be a power of 2, >= 2
// - CNT_W    8   width of the saturating event counter
// PORTS
// - clk        in   1      system clock; all logic on posedge
// - rst        in   1      reset; asynchronous, active-low
// - enable     in   1      1 = timestamp runs and edges are detected; 0 = both frozen
// - trigger    in   1      TSC trigger, same clock domain, level signal
// - clear      in   1      synchronous flush of FIFO, count, overflow and alarm
// - rd_en      in   1      pop request for the FIFO head
// - rd_valid   out  1      FIFO non-empty; rd_data is valid
// - rd_data    out  TS_W   timestamp at the FIFO head
// - event_cnt  out  CNT_W  detected edges (stored and dropped), saturating
// - overflow   out  1      sticky; an edge was dropped because the FIFO was full
// - alarm      out  1      sticky; at least one edge was detected since reset/clear
// BEHAVIOUR
// - Reset (async, rst=0): ts, trig_q, FIFO pointers, event_cnt, overflow, alarm all 0.
//   - Outputs: rd_valid=0, rd_data=0.
//   - Reset mid-operation discards all FIFO contents immediately.
// - Timestamp: ts increments by 1 each cycle while enable=1 and wraps 2^TS_W-1 -> 0.
//   - ts holds while enable=0. clear does not affect ts.
// - Edge detect: trig_q <= trigger every cycle, regardless of enable.
//   - evt = enable & trigger & ~trig_q.
//   - trig_q resets to 0, so trigger already high at reset release gives one event on the first enabled cycle.
// - Latency: evt in cycle n stores the ts value of cycle n.
//   - The entry is written at the end of cycle n; rd_valid rises in cycle n+1.
//   - event_cnt and alarm update in cycle n+1.
// - FIFO, show-ahead:
//   - rd_data = head whenever rd_valid=1.
//   - Pop when rd_en & rd_valid; rd_en while empty is ignored.
//   - rd_data holds its last value after the FIFO drains.
// - Full: evt with no pop in the same cycle drops the entry and sets overflow.
//   - evt with a pop in the same cycle stores the entry; overflow is not set.
// - Empty: a simultaneous evt and rd_en on an empty FIFO pushes only; no pop.
// - event_cnt: +1 per evt, saturates at 2^CNT_W-1; dropped events are counted.
// - alarm: set on any evt; cleared only by clear or reset.
// - clear=1 for one cycle empties the FIFO and zeroes event_cnt, overflow and alarm.
//   - clear beats a same-cycle evt (the event is lost) and a same-cycle rd_en.
//   - clear does not reset trig_q, so an ongoing high trigger does not re-fire.
// STRUCTURE
// - Package trig_log_pkg holds the defaults TS_W, DEPTH and CNT_W.
//   - It also holds localparam PTR_W = $clog2(DEPTH).
// - One sub-module, trig_log_fifo: synchronous DEPTH x TS_W FIFO.
//   - Pointers carry PTR_W+1 bits for the full/empty distinction.
//   - Ports: push, pop, flush, din, dout, empty, full.
// - Top level holds the timestamp counter, edge detect, counters and sticky flags.
// TESTING
// - Reset, then enable=1 with trigger held 0 for 20 cycles.
//   - Expect rd_valid=0, event_cnt=0, alarm=0, ts=20.
// - Trigger 0->1 at ts=5, held high for 10 cycles.
//   - Expect exactly one entry with rd_data=5, event_cnt=1, and alarm=1 from the next cycle.
// - 5 rising edges with no reads (DEPTH=4).
//   - Expect 4 entries, overflow=1, event_cnt=5.
//   - Reads return the first 4 timestamps in order.
// - FIFO full, then rd_en and a new edge in the same cycle.
//   - Expect no drop, overflow stays 0, and the new ts becomes the tail.
// - clear asserted in the same cycle as an edge.
//   - Expect FIFO empty, event_cnt=0, alarm=0, and no entry recorded next cycle.
// - Drive ts to 0xFFFF, edge at wrap, then rst pulsed low mid-cycle with 2 entries queued.
//   - Expect the stored ts=0xFFFF.
//   - After rst, all outputs are 0 immediately (asynchronously).

Source files
------------

// File: rtl/trig_log_pkg.sv
// Shared defaults for the trigger event logger and its timestamp FIFO.
package trig_log_pkg;
  localparam int TS_W  = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int PTR_W = $clog2(DEPTH);
endpackage

// File: rtl/trig_log_fifo.sv
// Show-ahead FIFO: dout is a register that tracks the head and holds its last value once drained.
module trig_log_fifo #(
  parameter int WIDTH   = trig_log_pkg::TS_W,
  parameter int ENTRIES = trig_log_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(ENTRIES);

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_next;
  logic [AW:0]      rd_ptr_next;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] head_next;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop      = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push     = push & (~full | do_pop);
  assign wr_ptr_next = wr_ptr + (AW+1)'(do_push);
  assign rd_ptr_next = rd_ptr + (AW+1)'(do_pop);

  // Next head comes from the incoming word when it lands in the head slot.
  always_comb begin
    head_next = dout;
    if (wr_ptr_next != rd_ptr_next) begin
      if (do_push && (wr_ptr[AW-1:0] == rd_ptr_next[AW-1:0])) begin
        head_next = din;
      end else begin
        head_next = mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      dout   <= head_next;
    end
  end
endmodule

// File: rtl/trigger_event_logger.sv
// Passive monitor: timestamps rising edges of trigger into a FIFO and keeps
// a saturating event count plus sticky overflow and alarm flags.
module trigger_event_logger #(
  parameter int TS_W  = trig_log_pkg::TS_W,
  parameter int DEPTH = trig_log_pkg::DEPTH,
  parameter int CNT_W = trig_log_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             trigger,
  input  logic             clear,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [TS_W-1:0]  rd_data,
  output logic [CNT_W-1:0] event_cnt,
  output logic             overflow,
  output logic             alarm
);
  logic [TS_W-1:0] ts_reg;
  logic            trig_q;
  logic            evt;
  logic            fifo_empty;
  logic            fifo_full;

  assign evt      = enable & trigger & ~trig_q;
  assign rd_valid = ~fifo_empty;

  trig_log_fifo #(
    .WIDTH   (TS_W),
    .ENTRIES (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt),
    .pop   (rd_en),
    .flush (clear),
    .din   (ts_reg),
    .dout  (rd_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // trig_q follows trigger even while disabled or clearing, so a held level never re-fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_reg <= '0;
      trig_q <= 1'b0;
    end else begin
      trig_q <= trigger;
      if (enable) begin
        ts_reg <= ts_reg + TS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      event_cnt <= '0;
      overflow  <= 1'b0;
      alarm     <= 1'b0;
    end else if (clear) begin
      event_cnt <= '0;
      overflow  <= 1'b0;
      alarm     <= 1'b0;
    end else if (evt) begin
      alarm <= 1'b1;
      if (event_cnt != '1) begin
        event_cnt <= event_cnt + CNT_W'(1);
      end
      if (fifo_full && !(rd_en && !fifo_empty)) begin
        overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_trigger_event_logger.sv
// Directed, table-driven bench for trigger_event_logger with hand-written wrap and async-reset sequences.
module tb_trigger_event_logger;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        trigger;
  logic        clear;
  logic        rd_en;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [7:0]  event_cnt;
  logic        overflow;
  logic        alarm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trigger_event_logger dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .trigger   (trigger),
    .clear     (clear),
    .rd_en     (rd_en),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .event_cnt (event_cnt),
    .overflow  (overflow),
    .alarm     (alarm)
  );

  typedef struct {
    int          rep;
    logic        rst_low;
    logic        en;
    logic        trig;
    logic        clr;
    logic        rd;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [7:0]  exp_cnt;
    logic        exp_ovf;
    logic        exp_alarm;
    logic [15:0] exp_ts;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rep, logic r, logic e, logic t, logic c, logic d,
                              logic ev, logic [15:0] dt, logic [7:0] cn,
                              logic o, logic a, logic [15:0] ts);
    vec_t x;
    x.rep = rep; x.rst_low = r; x.en = e; x.trig = t; x.clr = c; x.rd = d;
    x.exp_valid = ev; x.exp_data = dt; x.exp_cnt = cn;
    x.exp_ovf = o; x.exp_alarm = a; x.exp_ts = ts;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(string tag, logic v, logic [15:0] d, logic [7:0] c,
                             logic o, logic a, logic [15:0] ts);
    chk({tag, ".rd_valid"},  32'(rd_valid),   32'(v));
    chk({tag, ".rd_data"},   32'(rd_data),    32'(d));
    chk({tag, ".event_cnt"}, 32'(event_cnt),  32'(c));
    chk({tag, ".overflow"},  32'(overflow),   32'(o));
    chk({tag, ".alarm"},     32'(alarm),      32'(a));
    chk({tag, ".ts"},        32'(dut.ts_reg), 32'(ts));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; enable = 1'b0; trigger = 1'b0; clear = 1'b0; rd_en = 1'b0;
    repeat (3) tick();
    chk_outputs("reset", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b1;

    //                 rep rst en tr cl rd  val data    cnt ovf alm ts
    vecs.push_back(mk(20, 0, 1, 0, 0, 0,  0, 16'd0,  8'd0, 0, 0, 16'd20));
    vecs.push_back(mk(1,  1, 0, 0, 0, 0,  0, 16'd0,  8'd0, 0, 0, 16'd0));
    vecs.push_back(mk(5,  0, 1, 0, 0, 0,  0, 16'd0,  8'd0, 0, 0, 16'd5));
    vecs.push_back(mk(1,  0, 1, 1, 0, 0,  1, 16'd5,  8'd1, 0, 1, 16'd6));
    vecs.push_back(mk(9,  0, 1, 1, 0, 0,  1, 16'd5,  8'd1, 0, 1, 16'd15));
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  1, 16'd5,  8'd1, 0, 1, 16'd16));
    vecs.push_back(mk(1,  0, 1, 0, 0, 1,  0, 16'd5,  8'd1, 0, 1, 16'd17));
    vecs.push_back(mk(1,  0, 1, 0, 1, 0,  0, 16'd5,  8'd0, 0, 0, 16'd18));
    // five edges without reads: fifth is dropped
    vecs.push_back(mk(1,  0, 1, 1, 0, 0,  1, 16'd18, 8'd1, 0, 1, 16'd19));
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  1, 16'd18, 8'd1, 0, 1, 16'd20));
    vecs.push_back(mk(1,  0, 1, 1, 0, 0,  1, 16'd18, 8'd2, 0, 1, 16'd21));
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  1, 16'd18, 8'd2, 0, 1, 16'd22));
    vecs.push_back(mk(1,  0, 1, 1, 0, 0,  1, 16'd18, 8'd3, 0, 1, 16'd23));
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  1, 16'd18, 8'd3, 0, 1, 16'd24));
    vecs.push_back(mk(1,  0, 1, 1, 0, 0,  1, 16'd18, 8'd4, 0, 1, 16'd25));
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  1, 16'd18, 8'd4, 0, 1, 16'd26));
    vecs.push_back(mk(1,  0, 1, 1, 0, 0,  1, 16'd18, 8'd5, 1, 1, 16'd27));
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  1, 16'd18, 8'd5, 1, 1, 16'd28));
    vecs.push_back(mk(1,  0, 1, 0, 0, 1,  1, 16'd20, 8'd5, 1, 1, 16'd29));
    vecs.push_back(mk(1,  0, 1, 0, 0, 1,  1, 16'd22, 8'd5, 1, 1, 16'd30));
    vecs.push_back(mk(1,  0, 1, 0, 0, 1,  1, 16'd24, 8'd5, 1, 1, 16'd31));
    vecs.push_back(mk(1,  0, 1, 0, 0, 1,  0, 16'd24, 8'd5, 1, 1, 16'd32));
    vecs.push_back(mk(1,  0, 1, 0, 0, 1,  0, 16'd24, 8'd5, 1, 1, 16'd33));
    // refill, then pop and edge in the same cycle while full
    vecs.push_back(mk(1,  0, 1, 0, 1, 0,  0, 16'd24, 8'd0, 0, 0, 16'd34));
    vecs.push_back(mk(1,  0, 1, 1, 0, 0,  1, 16'd34, 8'd1, 0, 1, 16'd35));
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  1, 16'd34, 8'd1, 0, 1, 16'd36));
    vecs.push_back(mk(1,  0, 1, 1, 0, 0,  1, 16'd34, 8'd2, 0, 1, 16'd37));
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  1, 16'd34, 8'd2, 0, 1, 16'd38));
    vecs.push_back(mk(1,  0, 1, 1, 0, 0,  1, 16'd34, 8'd3, 0, 1, 16'd39));
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  1, 16'd34, 8'd3, 0, 1, 16'd40));
    vecs.push_back(mk(1,  0, 1, 1, 0, 0,  1, 16'd34, 8'd4, 0, 1, 16'd41));
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  1, 16'd34, 8'd4, 0, 1, 16'd42));
    vecs.push_back(mk(1,  0, 1, 1, 0, 1,  1, 16'd36, 8'd5, 0, 1, 16'd43));
    vecs.push_back(mk(1,  0, 1, 0, 0, 1,  1, 16'd38, 8'd5, 0, 1, 16'd44));
    vecs.push_back(mk(1,  0, 1, 0, 0, 1,  1, 16'd40, 8'd5, 0, 1, 16'd45));
    vecs.push_back(mk(1,  0, 1, 0, 0, 1,  1, 16'd42, 8'd5, 0, 1, 16'd46));
    vecs.push_back(mk(1,  0, 1, 0, 0, 1,  0, 16'd42, 8'd5, 0, 1, 16'd47));
    // edge and rd_en on empty: push only
    vecs.push_back(mk(1,  0, 1, 1, 0, 1,  1, 16'd47, 8'd6, 0, 1, 16'd48));
    vecs.push_back(mk(1,  0, 1, 0, 0, 1,  0, 16'd47, 8'd6, 0, 1, 16'd49));
    // disabled: frozen ts, no event, but trig_q still follows trigger
    vecs.push_back(mk(2,  0, 0, 1, 0, 0,  0, 16'd47, 8'd6, 0, 1, 16'd49));
    vecs.push_back(mk(1,  0, 1, 1, 0, 0,  0, 16'd47, 8'd6, 0, 1, 16'd50));
    // clear in the same cycle as an edge, then held trigger must not re-fire
    vecs.push_back(mk(1,  0, 1, 0, 0, 0,  0, 16'd47, 8'd6, 0, 1, 16'd51));
    vecs.push_back(mk(1,  0, 1, 1, 1, 0,  0, 16'd47, 8'd0, 0, 0, 16'd52));
    vecs.push_back(mk(1,  0, 1, 1, 0, 0,  0, 16'd47, 8'd0, 0, 0, 16'd53));

    foreach (vecs[i]) begin
      enable = vecs[i].en; trigger = vecs[i].trig; clear = vecs[i].clr; rd_en = vecs[i].rd;
      if (vecs[i].rst_low) rst = 1'b0;
      repeat (vecs[i].rep) tick();
      $display("vec %0d rep=%0d: rd_valid=%0b rd_data=%h event_cnt=%0d overflow=%0b alarm=%0b ts=%0d",
               i, vecs[i].rep, rd_valid, rd_data, event_cnt, overflow, alarm, dut.ts_reg);
      chk_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_cnt,
                  vecs[i].exp_ovf, vecs[i].exp_alarm, vecs[i].exp_ts);
      rst = 1'b1;
    end

    // Timestamp wrap: run ts up to 0xFFFF and log an edge there
    enable = 1'b1; trigger = 1'b0; clear = 1'b1; rd_en = 1'b0;
    tick();
    clear = 1'b0;
    repeat (16'hFFFF - 54) tick();
    $display("wrap approach: ts=%h", dut.ts_reg);
    chk("wrap.ts_max", 32'(dut.ts_reg), 32'h0000FFFF);
    trigger = 1'b1;
    tick();
    $display("wrap edge: rd_valid=%0b rd_data=%h event_cnt=%0d ts=%h", rd_valid, rd_data, event_cnt, dut.ts_reg);
    chk_outputs("wrap", 1'b1, 16'hFFFF, 8'd1, 1'b0, 1'b1, 16'h0000);
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
    $display("second edge: rd_valid=%0b rd_data=%h event_cnt=%0d ts=%h", rd_valid, rd_data, event_cnt, dut.ts_reg);
    chk_outputs("wrap2", 1'b1, 16'hFFFF, 8'd2, 1'b0, 1'b1, 16'h0002);

    // Asynchronous reset between clock edges with two entries queued
    trigger = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    $display("async reset: rd_valid=%0b rd_data=%h event_cnt=%0d overflow=%0b alarm=%0b ts=%h",
             rd_valid, rd_data, event_cnt, overflow, alarm, dut.ts_reg);
    chk_outputs("async_rst", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 16'h0000);
    tick();
    rst = 1'b1;
    tick();
    chk_outputs("post_rst", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
